// File: rtl/vram_fetch_arbiter_if.sv
// Bundle of the three renderer fetch ports and the shared VRAM read port.
// slave = arbiter side, master = renderers/VRAM side.
interface vram_fetch_arbiter_if #(
    parameter int ADDR_WIDTH = 15
);
    logic [ADDR_WIDTH-1:0] l0_addr;
    logic                  l0_strobe;
    logic                  l0_ack;
    logic [ADDR_WIDTH-1:0] l1_addr;
    logic                  l1_strobe;
    logic                  l1_ack;
    logic [ADDR_WIDTH-1:0] spr_addr;
    logic                  spr_strobe;
    logic                  spr_ack;
    logic [31:0]           rddata;
    logic [ADDR_WIDTH-1:0] vram_addr;
    logic                  vram_strobe;
    logic                  vram_ack;
    logic [31:0]           vram_rddata;
    logic                  busy;

    modport slave (
        input  l0_addr, l0_strobe,
        input  l1_addr, l1_strobe,
        input  spr_addr, spr_strobe,
        input  vram_ack, vram_rddata,
        output l0_ack, l1_ack, spr_ack,
        output rddata, vram_addr, vram_strobe, busy
    );

    modport master (
        output l0_addr, l0_strobe,
        output l1_addr, l1_strobe,
        output spr_addr, spr_strobe,
        output vram_ack, vram_rddata,
        input  l0_ack, l1_ack, spr_ack,
        input  rddata, vram_addr, vram_strobe, busy
    );
endinterface

// File: rtl/vram_fetch_arbiter.sv
// Three-way VRAM fetch arbiter, one outstanding read at a time.
// Define VRAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed l0>l1>spr.
module vram_fetch_arbiter #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    vram_fetch_arbiter_if.slave   bus
);
    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [3:0]            req;
    logic [1:0]            base;
    logic [2:0]            idx;
    logic [1:0]            win;
    logic                  win_vld;
    logic                  ack_cyc;

    assign req = {1'b0, bus.spr_strobe, bus.l1_strobe, bus.l0_strobe};

`ifdef VRAM_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    assign base = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && win_vld) begin
            ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign base = 2'd0;
`endif

    // Cyclic search starting at base; base is 0 for fixed priority.
    always_comb begin
        win_vld = 1'b0;
        win     = 2'd0;
        idx     = 3'd0;
        for (int i = 0; i < 3; i++) begin
            idx = {1'b0, base} + 3'(i);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (!win_vld && req[idx[1:0]]) begin
                win_vld = 1'b1;
                win     = idx[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = WAIT_ACK;
                    grant_d = win;
                    case (win)
                        2'd0:    addr_d = bus.l0_addr;
                        2'd1:    addr_d = bus.l1_addr;
                        default: addr_d = bus.spr_addr;
                    endcase
                end
            end
            WAIT_ACK: begin
                if (bus.vram_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
        end
    end

    assign ack_cyc         = (state_q == WAIT_ACK) && bus.vram_ack;
    assign bus.l0_ack      = ack_cyc && (grant_q == 2'd0);
    assign bus.l1_ack      = ack_cyc && (grant_q == 2'd1);
    assign bus.spr_ack     = ack_cyc && (grant_q == 2'd2);
    assign bus.rddata      = bus.vram_rddata;
    assign bus.vram_addr   = addr_q;
    assign bus.vram_strobe = (state_q == WAIT_ACK) && !bus.vram_ack;
    assign bus.busy        = (state_q == WAIT_ACK);
endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed bench for vram_fetch_arbiter: per-cycle vector table
// plus a continuous-strobe grant-order sequence.
module tb_vram_fetch_arbiter;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vram_fetch_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    vram_fetch_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          rst;
        logic [2:0]    s;
        logic          vack;
        logic [AW-1:0] l1a;
        logic          busy;
        logic          vs;
        logic [2:0]    ack;
        logic [AW-1:0] va;
    } vec_t;

    vec_t vec[20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] acks();
        return {bus.spr_ack, bus.l1_ack, bus.l0_ack};
    endfunction

    logic [2:0] exp_order[6];
    logic [2:0] a;
    int         n;
    bit         seen;

    initial begin
        // rst s vack l1a | busy vs ack va
        vec[0]  = '{0, 3'b000, 0, 15'h0010, 0, 0, 3'b000, 15'h0000};
        vec[1]  = '{0, 3'b000, 1, 15'h0010, 0, 0, 3'b000, 15'h0000};
        vec[2]  = '{0, 3'b100, 0, 15'h0010, 0, 0, 3'b000, 15'h0000};
        vec[3]  = '{0, 3'b000, 0, 15'h0010, 1, 1, 3'b000, 15'h1234};
        vec[4]  = '{0, 3'b000, 0, 15'h0010, 1, 1, 3'b000, 15'h1234};
        vec[5]  = '{0, 3'b000, 0, 15'h0010, 1, 1, 3'b000, 15'h1234};
        vec[6]  = '{0, 3'b000, 1, 15'h0010, 1, 0, 3'b100, 15'h1234};
        vec[7]  = '{0, 3'b000, 0, 15'h0010, 0, 0, 3'b000, 15'h1234};
        vec[8]  = '{0, 3'b010, 0, 15'h0010, 0, 0, 3'b000, 15'h1234};
        vec[9]  = '{0, 3'b010, 0, 15'h0020, 1, 1, 3'b000, 15'h0010};
        vec[10] = '{0, 3'b010, 1, 15'h0020, 1, 0, 3'b010, 15'h0010};
        vec[11] = '{0, 3'b010, 0, 15'h0020, 0, 0, 3'b000, 15'h0010};
        vec[12] = '{0, 3'b000, 0, 15'h0020, 1, 1, 3'b000, 15'h0020};
        vec[13] = '{0, 3'b000, 1, 15'h0020, 1, 0, 3'b010, 15'h0020};
        vec[14] = '{0, 3'b000, 0, 15'h0020, 0, 0, 3'b000, 15'h0020};
        vec[15] = '{0, 3'b001, 0, 15'h0020, 0, 0, 3'b000, 15'h0020};
        vec[16] = '{0, 3'b000, 0, 15'h0020, 1, 1, 3'b000, 15'h0100};
        vec[17] = '{1, 3'b000, 0, 15'h0020, 1, 1, 3'b000, 15'h0100};
        vec[18] = '{0, 3'b000, 1, 15'h0020, 0, 0, 3'b000, 15'h0000};
        vec[19] = '{0, 3'b000, 0, 15'h0020, 0, 0, 3'b000, 15'h0000};

`ifdef VRAM_ARB_ROUND_ROBIN_EN
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_order = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif

        rst             = 1'b1;
        bus.l0_addr     = 15'h0100;
        bus.l1_addr     = 15'h0010;
        bus.spr_addr    = 15'h1234;
        bus.l0_strobe   = 1'b0;
        bus.l1_strobe   = 1'b0;
        bus.spr_strobe  = 1'b0;
        bus.vram_ack    = 1'b0;
        bus.vram_rddata = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_vstrobe", 32'(bus.vram_strobe), 32'd0);
        chk("reset_vaddr", 32'(bus.vram_addr), 32'd0);
        chk("reset_acks", 32'(acks()), 32'd0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst            = vec[i].rst;
            bus.l0_strobe  = vec[i].s[0];
            bus.l1_strobe  = vec[i].s[1];
            bus.spr_strobe = vec[i].s[2];
            bus.vram_ack   = vec[i].vack;
            bus.l1_addr    = vec[i].l1a;
            #1;
            chk($sformatf("row%0d_busy", i), 32'(bus.busy), 32'(vec[i].busy));
            chk($sformatf("row%0d_vstrobe", i), 32'(bus.vram_strobe),
                32'(vec[i].vs));
            chk($sformatf("row%0d_acks", i), 32'(acks()), 32'(vec[i].ack));
            chk($sformatf("row%0d_vaddr", i), 32'(bus.vram_addr),
                32'(vec[i].va));
            if (vec[i].ack != 3'b000) begin
                chk($sformatf("row%0d_rddata", i), bus.rddata, 32'hDEADBEEF);
            end
        end

        // All strobes held high: record which requester is acked each round.
        @(negedge clk);
        rst            = 1'b0;
        bus.vram_ack   = 1'b0;
        bus.l0_strobe  = 1'b1;
        bus.l1_strobe  = 1'b1;
        bus.spr_strobe = 1'b1;
        for (int g = 0; g < 6; g++) begin
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 10) begin
                @(negedge clk);
                #1;
                if (bus.busy) seen = 1'b1;
                n++;
            end
            chk($sformatf("grant%0d_busy_seen", g), 32'(seen), 32'd1);
            bus.vram_ack = 1'b1;
            #1;
            a = acks();
            chk($sformatf("grant%0d_order", g), 32'(a), 32'(exp_order[g]));
            @(negedge clk);
            bus.vram_ack = 1'b0;
            #1;
            chk($sformatf("grant%0d_idle", g), 32'(bus.busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
